// File: rtl/pipe_imem_prefetch_pkg.sv
// Shared types, constants and helpers for the instruction prefetch buffer.
// Also carries the core-wide `XLEN / `IMEM_NOP / `INSTR_ALIGN defaults when no config header was seen.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_NOP
`define IMEM_NOP 32'h0000_0013
`endif
`ifndef INSTR_ALIGN
`define INSTR_ALIGN 2
`endif

package pipe_imem_prefetch_pkg;

    localparam int XLEN = `XLEN;
    localparam logic [XLEN-1:0] IMEM_NOP   = `IMEM_NOP;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((1 << `INSTR_ALIGN) - 1);

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pipe_sync_fifo.sv
// Single-clock FIFO with synchronous clear and a combinational head output.
module pipe_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every read, so stale words are never used.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pipe_imem_prefetch.sv
// In-order instruction prefetch buffer feeding the Fetch stage from a variable-latency memory.
// Define PREFETCH_BYPASS_EN to forward a response straight to Fetch when the buffer is empty.
module pipe_imem_prefetch
    import pipe_imem_prefetch_pkg::*;
#(
    parameter int               DEPTH           = 4,
    parameter int               MAX_OUTSTANDING = 2,
    parameter logic [`XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    output logic             o_imem_req_valid,
    input  logic             i_imem_req_ready,
    output logic [`XLEN-1:0] o_imem_req_addr,
    input  logic             i_imem_rsp_valid,
    input  logic [`XLEN-1:0] i_imem_rsp_data,
    output logic             o_instr_valid,
    output logic [`XLEN-1:0] o_instrF,
    output logic [`XLEN-1:0] o_PCF,
    output logic [`XLEN-1:0] o_PCPlus4F,
    input  logic             i_StallF,
    input  logic             i_redirect,
    input  logic [`XLEN-1:0] i_redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);

    logic            started;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            accept;
    logic            drop_zero;
    logic            bypass;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            head_valid;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    fifo_head;
    fetch_entry_t    head_entry;

    // Words already promised to the buffer: live in-flight requests plus buffered entries.
    assign occupancy = {1'b0, outstanding} - {1'b0, drop} + {1'b0, fifo_count};

    assign o_imem_req_valid = started && !i_redirect && (occupancy < DEPTH_C) && (outstanding < MAX_OUT_C);
    assign o_imem_req_addr  = fetch_pc;
    assign accept           = o_imem_req_valid && i_imem_req_ready;
    assign outstanding_next = outstanding + CW'(accept) - CW'(i_imem_rsp_valid);
    assign target_pc        = align_pc(i_redirect_pc);
    assign drop_zero        = (drop == '0);
    assign rsp_entry        = '{instr: i_imem_rsp_data, pc: rsp_pc};

`ifdef PREFETCH_BYPASS_EN
    assign bypass = fifo_empty && drop_zero && !i_redirect && i_imem_rsp_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that Fetch takes immediately never needs a FIFO slot.
    assign fifo_push  = i_imem_rsp_valid && drop_zero && !i_redirect && !(bypass && !i_StallF);
    assign fifo_pop   = !fifo_empty && !i_StallF && !i_redirect;
    assign head_valid = !fifo_empty || bypass;
    assign head_entry = bypass ? rsp_entry : fifo_head;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_instr_valid = head_valid;
        o_instrF      = IMEM_NOP;
        o_PCF         = rsp_pc;
        if (head_valid) begin
            o_instrF = head_entry.instr;
            o_PCF    = head_entry.pc;
        end
        o_PCPlus4F = o_PCF + PC_STEP;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding_next;
            if (i_redirect) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop     <= outstanding_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_STEP;
                if (i_imem_rsp_valid) begin
                    if (!drop_zero) drop   <= drop - CW'(1);
                    else            rsp_pc <= rsp_pc + PC_STEP;
                end
            end
        end
    end

    pipe_sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (i_redirect),
        .wdata (rsp_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_pipe_imem_prefetch.sv
// Randomised bench for pipe_imem_prefetch against an epoch-based stream model and an in-order memory model.
`ifndef XLEN
`define XLEN 32
`endif
module tb_pipe_imem_prefetch;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int FIRST_VALID_CYC = BYP ? 2 : 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid, req_ready, rsp_valid;
    logic [31:0] req_addr, rsp_data, instr, pc, pc4, redirect_pc;
    logic        instr_valid, stall, redirect;

    always #5 clk = ~clk;

    pipe_imem_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .o_instr_valid(instr_valid), .o_instrF(instr), .o_PCF(pc), .o_PCPlus4F(pc4),
        .i_StallF(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    req_t mq[$];

    int n_checks = 0, n_errors = 0;
    int cyc, epoch, buffered;
    logic [31:0] exp_pc, exp_req_addr;
    bit seen_valid, lat_phase, redir_on_rsp, redir_fired, capture_next;
    logic [31:0] first_pc_after;
    bit          stall_in, ready_in, redir_in;
    logic [31:0] redir_pc_in;
    int          lat_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0F0F_0013;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        #3;
        rstn = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0;
        #1;
        check("rst_req_valid", {31'b0, req_valid}, 0);
        check("rst_instr_valid", {31'b0, instr_valid}, 0);
        check("rst_instrF", instr, NOP);
        check("rst_PCF", pc, RESET_PC);
        check("rst_PCPlus4F", pc4, RESET_PC + 4);
        mq.delete();
        epoch = 0; buffered = 0; cyc = 0; seen_valid = 1'b0;
        exp_pc = RESET_PC; exp_req_addr = RESET_PC;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic step();
        bit rsp_now, redir, accept, consume, exp_valid, exp_req_valid;
        logic [31:0] rpc, tgt;
        int cur;
        req_t e;
        @(negedge clk);
        rsp_now = (mq.size() > 0) && (mq[0].due <= cyc);
        redir = redir_in;
        rpc   = redir_pc_in;
        if (redir_on_rsp && rsp_now && mq.size() >= 2) begin
            redir = 1'b1; rpc = 32'h0000_0100; redir_on_rsp = 1'b0; redir_fired = 1'b1;
        end
        rsp_valid   = rsp_now;
        rsp_data    = rsp_now ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
        stall       = stall_in;
        req_ready   = ready_in;
        redirect    = redir;
        redirect_pc = rpc;
        #2;
        cur = 0;
        foreach (mq[i]) if (mq[i].epoch == epoch) cur++;
        exp_valid     = (buffered > 0) || (BYP && rsp_now && mq[0].epoch == epoch && !redir);
        exp_req_valid = (cyc >= 1) && !redir && ((cur + buffered) < DEPTH) && (mq.size() < MAX_OUT);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
        check("req_valid", {31'b0, req_valid}, {31'b0, exp_req_valid});
        if (req_valid) check("req_addr", req_addr, exp_req_addr);
        if (instr_valid) begin
            check("head_PCF", pc, exp_pc);
            check("head_instrF", instr, mem_word(exp_pc));
            check("head_PCPlus4F", pc4, exp_pc + 4);
        end else begin
            check("empty_instrF", instr, NOP);
        end
        if (lat_phase && instr_valid && !seen_valid) begin
            seen_valid = 1'b1;
            check("first_valid_cycle", 32'(cyc), 32'(FIRST_VALID_CYC));
        end
        accept  = req_valid && req_ready;
        consume = instr_valid && !stall && !redir;
        if (rsp_now) begin
            e = mq.pop_front();
            if (e.epoch == epoch && !redir) buffered++;
        end
        if (consume) begin
            if (capture_next) begin first_pc_after = pc; capture_next = 1'b0; end
            buffered--;
            exp_pc += 4;
        end
        if (accept) begin
            mq.push_back('{addr: exp_req_addr, epoch: epoch, due: cyc + lat_in});
            exp_req_addr += 4;
        end
        if (redir) begin
            tgt = rpc & ~32'h3;
            epoch++; buffered = 0; exp_pc = tgt; exp_req_addr = tgt; capture_next = 1'b1;
        end
        check("occupancy", {31'b0, buffered <= DEPTH}, 1);
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        stall_in = 1'b0; ready_in = 1'b1; redir_in = 1'b0; redir_pc_in = '0; lat_in = 1;
        lat_phase = 1'b0; redir_on_rsp = 1'b0; redir_fired = 1'b0; capture_next = 1'b0;
        first_pc_after = '0;
        apply_reset();

        // Streaming from reset at L=1.
        lat_phase = 1'b1;
        run(20);
        lat_phase = 1'b0;
        check("saw_first_valid", {31'b0, seen_valid}, 1);

        // Long stall: buffer fills, requests stop, head holds.
        stall_in = 1'b1;
        run(10);
        #1;
        check("stall_req_valid", {31'b0, req_valid}, 0);
        check("stall_buffered", 32'(buffered), 32'(DEPTH));
        stall_in = 1'b0;
        run(15);

        // Drain, then L=3 with a redirect on the first returning response.
        ready_in = 1'b0;
        run(6);
        ready_in = 1'b1; lat_in = 3; redir_on_rsp = 1'b1;
        run(25);
        check("redirect_fired", {31'b0, redir_fired}, 1);
        check("post_redirect_pc", first_pc_after, 32'h0000_0100);
        lat_in = 1;

        // Unaligned redirect target.
        redir_in = 1'b1; redir_pc_in = 32'h0000_0203;
        step();
        redir_in = 1'b0;
        step();
        check("aligned_req_addr", req_addr, 32'h0000_0200);
        run(12);
        check("aligned_PCF_seen", first_pc_after, 32'h0000_0200);

        // Ready toggling with a redirect while req_valid is low.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                ready_in = (k == 0 || k == 3);
                redir_in = (r == 0 && k == 2);
                redir_pc_in = 32'h0000_0340;
                step();
            end
        end
        redir_in = 1'b0; ready_in = 1'b1;
        run(10);
        check("toggle_redirect_pc", first_pc_after, 32'h0000_0340);

        // Asynchronous reset with three entries buffered.
        stall_in = 1'b1; redir_in = 1'b1; redir_pc_in = 32'h0000_0040;
        step();
        redir_in = 1'b0;
        for (int i = 0; i < 30 && buffered != 3; i++) step();
        check("prefill_three", 32'(buffered), 3);
        stall_in = 1'b0;
        apply_reset();
        run(10);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            lat_in      = $urandom_range(1, 4);
            ready_in    = ($urandom_range(0, 3) != 0);
            stall_in    = ($urandom_range(0, 3) == 0);
            redir_in    = ($urandom_range(0, 29) == 0);
            redir_pc_in = $urandom_range(0, 4095);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
